// File: rtl/word_assembler_pkg.sv
// Shared types and widths for the byte-to-word assembler.
package word_assembler_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_e;

endpackage

// File: rtl/word_assembler_if.sv
// Byte-in / word-out handshake bundle; the timeout pulse exists only with WORD_ASSEMBLER_TIMEOUT_EN.
interface word_assembler_if
    import word_assembler_pkg::*;
();

    logic [BYTE_W-1:0] in;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] out;
    logic              en;
    logic [CNT_W-1:0]  count;
`ifdef WORD_ASSEMBLER_TIMEOUT_EN
    logic              timeout;
`endif

    modport master (
        output in,
        output in_valid,
        input  in_ready,
        input  out,
        input  en,
`ifdef WORD_ASSEMBLER_TIMEOUT_EN
        input  timeout,
`endif
        input  count
    );

    modport slave (
        input  in,
        input  in_valid,
        output in_ready,
        output out,
        output en,
`ifdef WORD_ASSEMBLER_TIMEOUT_EN
        output timeout,
`endif
        output count
    );

endinterface

// File: rtl/word_assembler_idle_timer.sv
// Loadable up-counter with clear; tc_o flags the increment that reaches LIMIT.
module idle_timer #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = inc_i && !clr_i && !load_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/word_assembler.sv
// Packs four accepted bytes (LSB first) into a word and strobes it out for one cycle.
// Optional partial-word timeout: WORD_ASSEMBLER_TIMEOUT_EN.
module word_assembler
    import word_assembler_pkg::*;
`ifdef WORD_ASSEMBLER_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    word_assembler_if.slave  bus
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              accept;
    logic              discard;

    assign accept = bus.in_valid && (state_q != EMIT);

`ifdef WORD_ASSEMBLER_TIMEOUT_EN
    logic timeout_q;

    idle_timer #(
        .LIMIT (TIMEOUT),
        .W     (8)
    ) u_idle_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept || (state_q != FILL)),
        .load_i     (1'b0),
        .load_val_i (8'd0),
        .inc_i      ((state_q == FILL) && !accept),
        .tc_o       (discard)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= discard;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign discard = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        out_d   = out_q;
        count_d = count_q;
        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    buf_d[count_q*BYTE_W +: BYTE_W] = bus.in;
                    count_d = count_q + 1'b1;
                    // Word is captured on the 4th accept so out is already valid while en is high.
                    if (count_q == CNT_W'(BYTES_PER_WORD - 1)) begin
                        state_d = EMIT;
                        out_d   = buf_d;
                    end else begin
                        state_d = FILL;
                    end
                end else if (discard) begin
                    state_d = IDLE;
                    buf_d   = '0;
                    count_d = '0;
                end
            end
            EMIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            out_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready = (state_q != EMIT);
    assign bus.en       = (state_q == EMIT);
    assign bus.out      = out_q;
    assign bus.count    = count_q;

endmodule

// File: doc/word_assembler.md
# word_assembler

Upstream feeder for the 32-bit `register` stage. It accepts a byte stream under a valid/ready handshake and packs four consecutive bytes into one 32-bit word, least-significant byte first. It then presents the word on `out` with a single-cycle `en` strobe, wired directly to the register's `in`/`en`. It sits between the byte-wide input path and the word-wide datapath registers.

## Interface
- `TIMEOUT`, default 16: idle cycles tolerated mid-word before the partial word is discarded. Only effective with `WORD_ASSEMBLER_TIMEOUT_EN`; legal range 2..255.
- `clk`  input  1  rising-edge clock
- `rst`  input  1  reset, synchronous, active-high
- `in`  input  8  byte data
- `in_valid`  input  1  byte on `in` is valid
- `in_ready`  output  1  block can accept a byte this cycle
- `out`  output  32  last assembled word, held until the next emit
- `en`  output  1  one-cycle load strobe for the downstream register
- `count`  output  2  bytes currently held in the partial word (0..3)
- `timeout`  output  1  one-cycle pulse when a partial word is discarded (port exists only with the macro)

## Operation
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- The k-th accepted byte of a word (k = 0..3) is written into bits [8k+7:8k] of an internal shift buffer. `out` is not touched while the word is being filled.
- States:
  - IDLE: `count`=0.
  - FILL: `count`=1..3.
  - EMIT: one cycle only.
- Transitions:
  - IDLE→FILL on accept.
  - FILL→FILL on accept while `count`<3.
  - FILL→EMIT on the accept of the 4th byte.
  - EMIT→IDLE unconditionally.
- In EMIT: `out` ← buffer, `en`=1, `in_ready`=0, `count`=0. Any byte offered during EMIT is not accepted; the source must hold it.
- `in_ready` = 1 in IDLE and FILL, 0 in EMIT. It is derived combinationally from the state.
- `en` is 0 in every cycle other than EMIT, so the downstream register is loaded exactly once per word.
- Reset (any state, including mid-word or during EMIT):
  - next state IDLE
  - buffer cleared, `count`=0
  - `out`=32'h0, `en`=0, `timeout`=0
  - bytes offered in a reset cycle are discarded.

## Timing
- Latency: `en` is high in the cycle immediately after the edge that accepts the 4th byte, with `out` valid in that same cycle.
- Maximum throughput: one word per 5 cycles with `in_valid` held high (4 accept cycles + 1 EMIT).
- Gaps in `in_valid` during FILL stall assembly. With the macro, gaps are subject to the timeout.
- `out` changes only on EMIT edges and on reset.
- Reset values: `out`=0, `en`=0, `count`=0, `timeout`=0. `in_ready` reads 1 in the first cycle after reset is released.

## Configuration
- `WORD_ASSEMBLER_TIMEOUT_EN` defined:
  - An idle counter runs in FILL. It is cleared on every accept, increments on each FILL cycle without an accept, and is cleared on entry to IDLE.
  - When it reaches `TIMEOUT`, the next state is IDLE, the buffer is cleared, `count`=0 and `timeout`=1 for exactly one cycle.
  - `en` is not asserted and `out` is unchanged.
  - The `timeout` port is present.
- Not defined:
  - Partial words are held indefinitely.
  - The `timeout` port, the counter and the `TIMEOUT` logic are absent.

## Structure
- Package `word_assembler_pkg` holds:
  - the state enum (IDLE, FILL, EMIT)
  - `BYTE_W`=8, `WORD_W`=32, `BYTES_PER_WORD`=4
- Sub-module `idle_timer`: loadable up-counter with clear and terminal-count flag. It is instantiated only under `WORD_ASSEMBLER_TIMEOUT_EN`.
- FSM, shift buffer and output register stay in `word_assembler`.

## Test plan
- Reset, then bytes 0x11, 0x22, 0x33, 0x44 back-to-back → `en`=1 for one cycle immediately after the 4th accept; `out`=32'h44332211; `in_ready`=0 in that cycle.
- `in_valid` held high with 8 bytes 0x01..0x08 → two `en` pulses 5 cycles apart, `out`=32'h04030201 then 32'h08070605; byte 0x05 is held across the EMIT cycle and accepted one cycle late.
- `in_valid` toggled every other cycle with 0xA1..0xA4 → `count` steps 1, 2, 3; single `en` pulse; `out`=32'hA4A3A2A1.
- Accept 0x55, 0x66, assert `rst` one cycle, then send 0xAA, 0xBB, 0xCC, 0xDD → no `en` before the 4th post-reset accept; `out`=0 until then, then 32'hDDCCBBAA.
- With macro and `TIMEOUT`=4: accept 0x01, 0x02, then idle → `timeout` pulses once at the 4th idle cycle; `en` stays 0; `out` unchanged; next 0x10..0x13 yields 32'h13121110.
- Without macro: accept 0x01, 0x02, idle 100 cycles, accept 0x03, 0x04 → single `en` with `out`=32'h04030201.
